naval_board_ctrl: RTL and testbench
===================================

Name: naval_board_ctrl

Overview:
- Parametrised successor to the fixed 7x5 position/attack register matrices of the naval-battle board.
- Holds the ship placement map and the attack map in one block.
- Accepts fire strobes at (row,col) coordinates and classifies each shot as hit, miss, repeat or invalid.
- Keeps hit/shot counters, runs a SETUP/PLAY/OVER game FSM and drives the column-scanned LED matrix with view modes and blink.

Parameters:
- ROWS, 7, board rows (matrix lines), 2..16
- COLS, 5, board columns (matrix columns), 2..16
- SCAN_DIV, 4, clk cycles per scanned column = 2^SCAN_DIV
- RW, $clog2(ROWS), row coordinate width (derived)
- CW, $clog2(COLS), column coordinate width (derived)
- NW, $clog2(ROWS*COLS+1), counter width (derived)

Ports:
- clk  in  1  system clock
- clr  in  1  reset; asynchronous and active-high
- load  in  1  one-cycle strobe; latch ship_map (SETUP only)
- ship_map  in  ROWS*COLS  placement; bit r*COLS+c = cell (r,c)
- start  in  1  one-cycle strobe; SETUP->PLAY, OVER->SETUP
- fire  in  1  one-cycle strobe; shot at (row,col)
- row  in  RW  shot row
- col  in  CW  shot column
- view  in  1  PLAY display: 0 = ships, 1 = attacks
- m_col  out  COLS  one-hot active-high column select
- m_line  out  ROWS  active-high pixels of selected column; bit r = row r
- result_valid  out  1  one-cycle pulse per accepted fire
- result_code  out  2  00 miss, 01 hit, 10 repeat, 11 invalid; held until next result
- hits  out  NW  ship cells hit
- shots  out  NW  valid non-repeat shots
- ships_total  out  NW  popcount of latched map
- state  out  2  00 SETUP, 01 PLAY, 10 OVER
- game_over  out  1  state==OVER

Behaviour:
- Reset (clr=1, async): ship and attack maps 0; hits, shots, ships_total 0; state SETUP; result_valid 0; result_code 00; scan column 0 (m_col = 1); prescaler and blink 0.
- All updates on rising clk; outputs registered except m_line.
- m_line is a combinational function of registered maps, scan column, view and blink.

FSM:
- SETUP, load: ship map <= ship_map; ships_total <= popcount; visible next cycle. Load in PLAY or OVER is ignored.
- SETUP, start: go to PLAY only if ships_total != 0. Otherwise stay in SETUP.
- PLAY -> OVER: on the edge that registers the hit making hits == ships_total.
- OVER, start: go to SETUP; clear attack map, hits, shots and result_code. Ship map is kept.
- Fire outside PLAY: ignored, no result_valid.

Fire (PLAY), sampled at edge k; result_valid high during cycle k+1; counters and map updated at edge k:
- row >= ROWS or col >= COLS: code 11; no map or counter change.
- Cell already attacked: code 10; no change.
- Otherwise: set attack bit, shots+1; code 01 and hits+1 if ship bit set, else code 00.
- Counters never exceed ROWS*COLS, so no wrap is possible.

Simultaneous strobes:
- fire and start in the same cycle in PLAY: fire processed, start ignored.
- load and start in the same cycle in SETUP: load takes effect, start evaluated against the new popcount.

Scan:
- Prescaler counts 0..2^SCAN_DIV-1. On wrap, the column advances; at COLS-1 it goes to 0.
- blink toggles each time column COLS-1 wraps to 0 (one full frame).
- m_col[c] = 1 iff scan column == c.

m_line[r] for scan column c:
- SETUP: ship(r,c).
- PLAY, view=0: ship(r,c).
- PLAY, view=1: (attack & ship), or (attack & ~ship & blink). Hits steady, misses blink.
- OVER: (attack & ship) & blink, i.e. the whole hit pattern flashes.

Test Plan:
- Reset, then clr pulse mid-scan: all outputs 0, state 00, m_col=5'b00001 immediately without a clk edge; then m_col walks 00001->00010->...->10000->00001, 16 clk per step.
- Load map with cells (0,0),(3,2),(6,4), start: ships_total=3, state 01; start with an all-zero map leaves state 00.
- PLAY: fire (3,2) -> pulse, code 01, hits=1, shots=1; fire (1,1) -> code 00, shots=2; fire (3,2) again -> code 10, counters unchanged.
- Fire row=7 col=0 -> code 11, shots unchanged; fire row=0 col=5 -> code 11.
- Hit (0,0) then (6,4): the edge of the last hit gives state 10, game_over=1, hits=3; a further fire produces no pulse; start returns to 00 with hits=shots=0 and ships_total=3.
- PLAY view=1 after a hit at (3,2) and a miss at (1,1): column 2 shows m_line[3]=1 steady; column 1 shows m_line[1] toggling each frame; view=0 shows the ship bits only.

Source files
------------

// File: rtl/naval_board_ctrl.sv
// Naval-battle board controller: ship and attack maps, shot classification,
// game FSM and column-scanned LED matrix drive.
module naval_board_ctrl #(
    parameter  int ROWS     = 7,
    parameter  int COLS     = 5,
    parameter  int SCAN_DIV = 4,
    localparam int RW       = $clog2(ROWS),
    localparam int CW       = $clog2(COLS),
    localparam int NW       = $clog2(ROWS*COLS+1)
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 load,
    input  logic [ROWS*COLS-1:0] ship_map,
    input  logic                 start,
    input  logic                 fire,
    input  logic [RW-1:0]        row,
    input  logic [CW-1:0]        col,
    input  logic                 view,
    output logic [COLS-1:0]      m_col,
    output logic [ROWS-1:0]      m_line,
    output logic                 result_valid,
    output logic [1:0]           result_code,
    output logic [NW-1:0]        hits,
    output logic [NW-1:0]        shots,
    output logic [NW-1:0]        ships_total,
    output logic [1:0]           state,
    output logic                 game_over
);

    localparam int N  = ROWS * COLS;
    localparam int IW = $clog2(N);
    localparam logic [RW:0]   ROWS_L = (RW+1)'(ROWS);
    localparam logic [CW:0]   COLS_L = (CW+1)'(COLS);
    localparam logic [NW-1:0] ONE_N  = NW'(1);

    typedef enum logic [1:0] {
        S_SETUP = 2'b00,
        S_PLAY  = 2'b01,
        S_OVER  = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        R_MISS    = 2'b00,
        R_HIT     = 2'b01,
        R_REPEAT  = 2'b10,
        R_INVALID = 2'b11
    } code_t;

    state_t                state_q;
    code_t                 code_q;
    logic [N-1:0]          ship_q;
    logic [N-1:0]          attack_q;
    logic [SCAN_DIV-1:0]   presc;
    logic [CW-1:0]         scan_col;
    logic                  blink;

    logic                  shot_ok;
    logic [IW-1:0]         cell_idx;
    logic                  cell_ship;
    logic                  cell_seen;
    logic [NW-1:0]         load_total;
    logic [NW-1:0]         setup_total;

    function automatic logic [NW-1:0] popcount(input logic [N-1:0] m);
        logic [NW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < N; i++) cnt = cnt + NW'(m[i]);
        return cnt;
    endfunction

    // NOTE: every signal driven in always_comb gets a default first so no latch is inferred.
    always_comb begin
        shot_ok     = ({1'b0, row} < ROWS_L) && ({1'b0, col} < COLS_L);
        cell_idx    = IW'(row) * IW'(COLS) + IW'(col);
        cell_ship   = 1'b0;
        cell_seen   = 1'b0;
        if (shot_ok) begin
            cell_ship = ship_q[cell_idx];
            cell_seen = attack_q[cell_idx];
        end
        load_total  = popcount(ship_map);
        // A load in the same cycle as start must be judged on the new map.
        setup_total = load ? load_total : ships_total;
    end

    // NOTE: sequential state uses non-blocking assignments only, so all registers
    // see pre-edge values regardless of statement order.
    // NOTE: the maps are flop arrays, not RAM, so they take the async reset like any register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q      <= S_SETUP;
            code_q       <= R_MISS;
            result_valid <= 1'b0;
            ship_q       <= '0;
            attack_q     <= '0;
            hits         <= '0;
            shots        <= '0;
            ships_total  <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state_q)
                S_SETUP: begin
                    if (load) begin
                        ship_q      <= ship_map;
                        ships_total <= load_total;
                    end
                    if (start && setup_total != '0) state_q <= S_PLAY;
                end
                S_PLAY: begin
                    if (fire) begin
                        result_valid <= 1'b1;
                        if (!shot_ok) begin
                            code_q <= R_INVALID;
                        end else if (cell_seen) begin
                            code_q <= R_REPEAT;
                        end else begin
                            attack_q[cell_idx] <= 1'b1;
                            shots              <= shots + ONE_N;
                            if (cell_ship) begin
                                code_q <= R_HIT;
                                hits   <= hits + ONE_N;
                                if (hits + ONE_N == ships_total) state_q <= S_OVER;
                            end else begin
                                code_q <= R_MISS;
                            end
                        end
                    end
                end
                S_OVER: begin
                    if (start) begin
                        state_q  <= S_SETUP;
                        code_q   <= R_MISS;
                        attack_q <= '0;
                        hits     <= '0;
                        shots    <= '0;
                    end
                end
                default: state_q <= S_SETUP;
            endcase
        end
    end

    // Column scan: one column per 2^SCAN_DIV clocks, blink flips once per frame.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            presc    <= '0;
            scan_col <= '0;
            m_col    <= COLS'(1);
            blink    <= 1'b0;
        end else begin
            presc <= presc + SCAN_DIV'(1);
            if (presc == '1) begin
                m_col <= {m_col[COLS-2:0], m_col[COLS-1]};
                if (scan_col == CW'(COLS-1)) begin
                    scan_col <= '0;
                    blink    <= ~blink;
                end else begin
                    scan_col <= scan_col + CW'(1);
                end
            end
        end
    end

    always_comb begin
        m_line = '0;
        for (int r = 0; r < ROWS; r++) begin
            logic [IW-1:0] idx;
            logic          s;
            logic          a;
            idx = IW'(r * COLS) + IW'(scan_col);
            s   = ship_q[idx];
            a   = attack_q[idx];
            unique case (state_q)
                S_PLAY:  m_line[r] = view ? ((a & s) | (a & ~s & blink)) : s;
                S_OVER:  m_line[r] = a & s & blink;
                default: m_line[r] = s;
            endcase
        end
    end

    assign state       = state_q;
    assign result_code = code_q;
    assign game_over   = (state_q == S_OVER);

endmodule

// File: tb/tb_naval_board_ctrl.sv
// Directed bench for naval_board_ctrl: expected shot codes are queued when a
// shot is driven and compared when the result pulse appears.
module tb_naval_board_ctrl;

    localparam int ROWS = 7;
    localparam int COLS = 5;
    localparam int N    = ROWS * COLS;

    localparam logic [1:0] C_MISS = 2'b00;
    localparam logic [1:0] C_HIT  = 2'b01;
    localparam logic [1:0] C_REP  = 2'b10;
    localparam logic [1:0] C_INV  = 2'b11;

    logic            clk;
    logic            clr;
    logic            load;
    logic [N-1:0]    ship_map;
    logic            start;
    logic            fire;
    logic [2:0]      row;
    logic [2:0]      col;
    logic            view;
    logic [COLS-1:0] m_col;
    logic [ROWS-1:0] m_line;
    logic            result_valid;
    logic [1:0]      result_code;
    logic [5:0]      hits;
    logic [5:0]      shots;
    logic [5:0]      ships_total;
    logic [1:0]      state;
    logic            game_over;

    logic [1:0] exp_q[$];
    int         n_checks;
    int         n_errors;

    naval_board_ctrl #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4)) dut (
        .clk(clk), .clr(clr), .load(load), .ship_map(ship_map), .start(start),
        .fire(fire), .row(row), .col(col), .view(view), .m_col(m_col),
        .m_line(m_line), .result_valid(result_valid), .result_code(result_code),
        .hits(hits), .shots(shots), .ships_total(ships_total), .state(state),
        .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic l, input logic s, input logic [N-1:0] m);
        @(negedge clk);
        load = l; start = s; ship_map = m;
        @(negedge clk);
        load = 1'b0; start = 1'b0;
    endtask

    task automatic shoot(input logic [2:0] r, input logic [2:0] c,
                         input logic [1:0] code, input logic s);
        @(negedge clk);
        row = r; col = c; fire = 1'b1; start = s;
        exp_q.push_back(code);
        @(negedge clk);
        fire = 1'b0; start = 1'b0;
        check("result_valid", 32'(result_valid), 32'd1);
        if (exp_q.size() > 0) begin
            logic [1:0] e;
            e = exp_q.pop_front();
            if (result_valid) check("result_code", 32'(result_code), 32'(e));
        end
    endtask

    task automatic wait_col(input int c);
        int k;
        k = 0;
        while (m_col !== COLS'(1 << c) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("wait_col", 32'(m_col), 32'(1 << c));
    endtask

    initial begin
        logic [ROWS-1:0] first_line;
        n_checks = 0; n_errors = 0;
        clr = 1'b1; load = 1'b0; start = 1'b0; fire = 1'b0;
        ship_map = '0; row = '0; col = '0; view = 1'b0;

        #12;
        check("rst_m_col", 32'(m_col), 32'd1);
        check("rst_state", 32'(state), 32'd0);
        check("rst_counts", {8'd0, 6'(hits), 6'(shots), 6'(ships_total), 1'b0, result_valid, result_code}, 32'd0);
        @(negedge clk) clr = 1'b0;

        // Mid-scan asynchronous clear, checked between clock edges
        repeat (40) @(negedge clk);
        #2 clr = 1'b1;
        #1;
        check("async_m_col", 32'(m_col), 32'd1);
        check("async_state", 32'(state), 32'd0);
        @(negedge clk) clr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            repeat (16) @(negedge clk);
            check("scan_walk", 32'(m_col), 32'd1 << (k % 5));
        end

        // Setup: empty-map start refused, then load and start
        pulse(1'b0, 1'b1, '0);
        check("start_empty", 32'(state), 32'd0);
        pulse(1'b1, 1'b0, N'((64'd1 << 0) | (64'd1 << 17) | (64'd1 << 34)));
        check("ships_total", 32'(ships_total), 32'd3);
        pulse(1'b0, 1'b1, '0);
        check("start_play", 32'(state), 32'd1);

        // Shots
        shoot(3'd3, 3'd2, C_HIT, 1'b0);
        check("hit_counts", {hits, shots}, {6'd1, 6'd1});
        @(negedge clk);
        check("pulse_width", 32'(result_valid), 32'd0);
        check("code_held", 32'(result_code), 32'(C_HIT));
        shoot(3'd1, 3'd1, C_MISS, 1'b0);
        check("miss_counts", {hits, shots}, {6'd1, 6'd2});
        shoot(3'd3, 3'd2, C_REP, 1'b0);
        check("repeat_counts", {hits, shots}, {6'd1, 6'd2});
        shoot(3'd7, 3'd0, C_INV, 1'b0);
        shoot(3'd0, 3'd5, C_INV, 1'b0);
        check("invalid_counts", {hits, shots}, {6'd1, 6'd2});

        // Display: attack view, hit steady and miss blinking
        view = 1'b1;
        wait_col(2);
        check("view1_col2", 32'(m_line), 32'b0001000);
        wait_col(1);
        first_line = m_line;
        check("view1_col1_shape", 32'(first_line & 7'b1111101), 32'd0);
        repeat (80) @(negedge clk);
        check("frame_col", 32'(m_col), 32'b00010);
        check("view1_col1_toggle", 32'(m_line), 32'(first_line ^ 7'b0000010));
        wait_col(2);
        check("view1_col2_steady", 32'(m_line), 32'b0001000);
        view = 1'b0;
        wait_col(1);
        check("view0_col1", 32'(m_line), 32'd0);
        wait_col(4);
        check("view0_col4", 32'(m_line), 32'b1000000);
        wait_col(0);
        check("view0_col0", 32'(m_line), 32'b0000001);

        // Finish the game
        shoot(3'd0, 3'd0, C_HIT, 1'b0);
        check("not_over_yet", 32'(state), 32'd1);
        shoot(3'd6, 3'd4, C_HIT, 1'b0);
        check("over_state", {state, game_over}, {2'b10, 1'b1});
        check("over_counts", {hits, shots}, {6'd3, 6'd4});
        @(negedge clk);
        row = 3'd2; col = 3'd2; fire = 1'b1;
        @(negedge clk);
        fire = 1'b0;
        check("fire_ignored", 32'(result_valid), 32'd0);
        check("fire_ignored_shots", 32'(shots), 32'd4);
        pulse(1'b1, 1'b0, '0);
        check("load_ignored", 32'(ships_total), 32'd3);
        pulse(1'b0, 1'b1, '0);
        check("restart_state", {state, game_over}, {2'b00, 1'b0});
        check("restart_counts", {hits, shots, ships_total}, {6'd0, 6'd0, 6'd3});
        check("restart_code", 32'(result_code), 32'd0);

        // Load and start together, then fire and start together
        pulse(1'b1, 1'b1, N'((64'd1 << 0) | (64'd1 << 5)));
        check("load_start", {state, ships_total}, {2'b01, 6'd2});
        shoot(3'd1, 3'd1, C_MISS, 1'b1);
        check("fire_start", {state, shots}, {2'b01, 6'd1});
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
